// File: rtl/mov_byte_pipe_pkg.sv
// Shared cpu constants and byte-lane select type for the byte-move path.
package mov_byte_pipe_pkg;

    localparam int unsigned CPU_NREG  = 32;
    localparam int unsigned CPU_AW    = 5;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned LANE_SEL_W = 2;

    typedef enum logic [LANE_SEL_W-1:0] {
        LANE_B0 = 2'd0,
        LANE_B1 = 2'd1,
        LANE_B2 = 2'd2,
        LANE_B3 = 2'd3
    } lane_e;

endpackage

// File: rtl/mov_byte_pipe_merge.sv
// Byte-lane merge: replaces one byte lane of a word, leaving the others intact.
module byte_lane_merge
    import mov_byte_pipe_pkg::*;
(
    input  lane_e              lane,
    input  logic [BYTE_W-1:0]  lane_byte,
    input  logic [WORD_W-1:0]  word,
    output logic [WORD_W-1:0]  merged
);

    always_comb begin
        merged = word;
        case (lane)
            LANE_B0: merged[7:0]   = lane_byte;
            LANE_B1: merged[15:8]  = lane_byte;
            LANE_B2: merged[23:16] = lane_byte;
            LANE_B3: merged[31:24] = lane_byte;
            default: merged        = word;
        endcase
    end

endmodule

// File: rtl/mov_byte_pipe.sv
// Three-stage MOVB executor: register request, read+merge with forwarding, write back.
module mov_byte_pipe
    import mov_byte_pipe_pkg::*;
#(
    parameter int unsigned NREG = CPU_NREG,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [AW-1:0]         req_rd,
    input  logic [LANE_SEL_W-1:0] req_byte_sel,
    input  logic [BYTE_W-1:0]     req_byte,
    input  logic                  flush,
    output logic                  rf_rd_en,
    output logic [AW-1:0]         rf_rd_addr,
    input  logic [WORD_W-1:0]     rf_rd_data,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_wr_addr,
    output logic [WORD_W-1:0]     rf_wr_data,
    output logic                  busy
);

    logic              a_valid, b_valid, c_valid, d_valid;
    logic [AW-1:0]     a_rd, b_rd, c_rd, d_rd;
    lane_e             a_sel, b_sel;
    logic [BYTE_W-1:0] a_byte, b_byte;
    logic [WORD_W-1:0] c_data, d_data;
    logic [WORD_W-1:0] b_operand, b_merged;

    // Operand select: r0 reads zero, then youngest in-flight result, then regfile.
    // D covers the read that raced the C write, since the regfile returns old data.
    always_comb begin
        b_operand = rf_rd_data;
        if (b_rd == '0)
            b_operand = '0;
        else if (c_valid && (c_rd == b_rd))
            b_operand = c_data;
        else if (d_valid && (d_rd == b_rd))
            b_operand = d_data;
    end

    byte_lane_merge u_merge (
        .lane      (b_sel),
        .lane_byte (b_byte),
        .word      (b_operand),
        .merged    (b_merged)
    );

    // Pipeline registers; flush squashes A/B/new requests, C still writes, D is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_rd    <= '0;
            a_sel   <= LANE_B0;
            a_byte  <= '0;
            b_valid <= 1'b0;
            b_rd    <= '0;
            b_sel   <= LANE_B0;
            b_byte  <= '0;
            c_valid <= 1'b0;
            c_rd    <= '0;
            c_data  <= '0;
            d_valid <= 1'b0;
            d_rd    <= '0;
            d_data  <= '0;
        end else begin
            a_valid <= req_valid & ~flush;
            a_rd    <= req_rd;
            a_sel   <= lane_e'(req_byte_sel);
            a_byte  <= req_byte;
            b_valid <= a_valid & ~flush;
            b_rd    <= a_rd;
            b_sel   <= a_sel;
            b_byte  <= a_byte;
            c_valid <= b_valid & ~flush;
            c_rd    <= b_rd;
            c_data  <= b_merged;
            d_valid <= c_valid;
            d_rd    <= c_rd;
            d_data  <= c_data;
        end
    end

    assign rf_rd_en   = a_valid;
    assign rf_rd_addr = a_rd;
    assign rf_we      = c_valid & (c_rd != '0);
    assign rf_wr_addr = c_rd;
    assign rf_wr_data = c_data;
    assign busy       = a_valid | b_valid | c_valid;

endmodule

// File: tb/tb_mov_byte_pipe.sv
// Directed bench for mov_byte_pipe with a behavioural old-data register file.
module tb_mov_byte_pipe;

    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [AW-1:0] req_rd;
    logic [1:0]    req_byte_sel;
    logic [7:0]    req_byte;
    logic          flush;
    logic          rf_rd_en;
    logic [AW-1:0] rf_rd_addr;
    logic [31:0]   rf_rd_data;
    logic          rf_we;
    logic [AW-1:0] rf_wr_addr;
    logic [31:0]   rf_wr_data;
    logic          busy;

    logic [31:0]   rf_mem [32];
    int            wr_cnt;
    int            n_run  = 0;
    int            n_fail = 0;
    int            wr_snap;

    mov_byte_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_byte_sel (req_byte_sel),
        .req_byte     (req_byte),
        .flush        (flush),
        .rf_rd_en     (rf_rd_en),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .rf_we        (rf_we),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Register file: synchronous read returning old data on read-during-write; preloads in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
            rf_mem[0]  <= 32'hDEADBEEF;
            rf_mem[3]  <= 32'h11223344;
            rf_mem[7]  <= 32'hFFFFFFFF;
            rf_rd_data <= 32'h0;
            wr_cnt     <= 0;
        end else begin
            if (rf_we) begin
                rf_mem[rf_wr_addr] <= rf_wr_data;
                wr_cnt <= wr_cnt + 1;
            end
            if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int rd, input int sel, input logic [7:0] b);
        req_valid    = v;
        req_rd       = AW'(rd);
        req_byte_sel = 2'(sel);
        req_byte     = b;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 0, 0, 8'h00);
        tick();
        tick();
        chk("rst_we",      32'(rf_we), 32'h0);
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_rd_en",   32'(rf_rd_en), 32'h0);
        chk("rst_wr_addr", 32'(rf_wr_addr), 32'h0);
        chk("rst_wr_data", rf_wr_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single op: r3 lane 2
        drive(1'b1, 3, 2, 8'hAA);
        tick();
        drive(1'b0, 0, 0, 8'h00);
        chk("single_rd_en", 32'(rf_rd_en), 32'h1);
        chk("single_rd_addr", 32'(rf_rd_addr), 32'd3);
        chk("single_busy", 32'(busy), 32'h1);
        tick();
        tick();
        chk("single_we", 32'(rf_we), 32'h1);
        chk("single_addr", 32'(rf_wr_addr), 32'd3);
        chk("single_data", rf_wr_data, 32'h11AA3344);
        tick();
        chk("single_we_off", 32'(rf_we), 32'h0);
        chk("single_busy_off", 32'(busy), 32'h0);
        chk("single_mem", rf_mem[3], 32'h11AA3344);

        // Back-to-back: r5 all four lanes
        drive(1'b1, 5, 0, 8'hDD);
        tick();
        drive(1'b1, 5, 1, 8'hCC);
        tick();
        drive(1'b1, 5, 2, 8'hBB);
        tick();
        chk("b2b_we0", 32'(rf_we), 32'h1);
        chk("b2b_d0", rf_wr_data, 32'h000000DD);
        drive(1'b1, 5, 3, 8'hAA);
        tick();
        drive(1'b0, 0, 0, 8'h00);
        chk("b2b_d1", rf_wr_data, 32'h0000CCDD);
        tick();
        chk("b2b_d2", rf_wr_data, 32'h00BBCCDD);
        tick();
        chk("b2b_we3", 32'(rf_we), 32'h1);
        chk("b2b_d3", rf_wr_data, 32'hAABBCCDD);
        tick();
        chk("b2b_mem", rf_mem[5], 32'hAABBCCDD);

        // Gap of one: second op must see the first via the write shadow
        drive(1'b1, 7, 0, 8'h00);
        tick();
        drive(1'b0, 0, 0, 8'h00);
        tick();
        drive(1'b1, 7, 3, 8'h12);
        tick();
        drive(1'b0, 0, 0, 8'h00);
        chk("gap_d0", rf_wr_data, 32'hFFFFFF00);
        tick();
        tick();
        chk("gap_we1", 32'(rf_we), 32'h1);
        chk("gap_d1", rf_wr_data, 32'h12FFFF00);
        tick();

        // r0 target: no write, operand forced to zero even with r0 in C
        wr_snap = wr_cnt;
        drive(1'b1, 0, 1, 8'h55);
        tick();
        drive(1'b1, 0, 0, 8'h01);
        tick();
        drive(1'b0, 0, 0, 8'h00);
        tick();
        chk("r0_we0", 32'(rf_we), 32'h0);
        chk("r0_data0", rf_wr_data, 32'h00005500);
        tick();
        chk("r0_we1", 32'(rf_we), 32'h0);
        chk("r0_data1", rf_wr_data, 32'h00000001);
        chk("r0_busy", 32'(busy), 32'h1);
        tick();
        chk("r0_busy_off", 32'(busy), 32'h0);
        chk("r0_no_write", 32'(wr_cnt - wr_snap), 32'h0);

        // Flush while the first of three is in C
        wr_snap = wr_cnt;
        drive(1'b1, 9, 0, 8'h11);
        tick();
        drive(1'b1, 9, 1, 8'h22);
        tick();
        drive(1'b1, 9, 2, 8'h33);
        tick();
        drive(1'b1, 9, 3, 8'h44);
        flush = 1'b1;
        chk("flush_we", 32'(rf_we), 32'h1);
        chk("flush_data", rf_wr_data, 32'h00000011);
        tick();
        flush = 1'b0;
        drive(1'b0, 0, 0, 8'h00);
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_we_off", 32'(rf_we), 32'h0);
        tick();
        tick();
        tick();
        chk("flush_one_write", 32'(wr_cnt - wr_snap), 32'h1);
        chk("flush_mem", rf_mem[9], 32'h00000011);
        drive(1'b1, 9, 1, 8'h66);
        tick();
        drive(1'b0, 0, 0, 8'h00);
        tick();
        tick();
        chk("post_flush_data", rf_wr_data, 32'h00006611);
        tick();

        // Async reset between edges with an op in C
        drive(1'b1, 11, 0, 8'hAB);
        tick();
        drive(1'b1, 11, 1, 8'hCD);
        tick();
        drive(1'b0, 0, 0, 8'h00);
        tick();
        chk("pre_rst_we", 32'(rf_we), 32'h1);
        wr_snap = wr_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_we", 32'(rf_we), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_rd_en", 32'(rf_rd_en), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_mem", rf_mem[11], 32'h0);
        drive(1'b1, 11, 2, 8'hEE);
        tick();
        drive(1'b0, 0, 0, 8'h00);
        tick();
        tick();
        chk("post_rst_we", 32'(rf_we), 32'h1);
        chk("post_rst_data", rf_wr_data, 32'h00EE0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mov_byte_pipe.md
Name: mov_byte_pipe

Overview:
- Three-stage pipelined executor for byte-move (MOVB) instructions.
- Accepts (rd, byte_sel, byte), reads rd from the register file, and inserts the byte into lane byte_sel.
- Writes the merged word back to the register file.
- Sits between decode and the register file, wrapping the byte-merge datapath; forwards in-flight results so back-to-back MOVBs to the same register see each other's bytes.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width; must equal ceil(log2(NREG)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  MOVB request present this cycle.
- req_rd  in  AW  destination/source register.
- req_byte_sel  in  2  target lane (0 = bits 7:0 … 3 = bits 31:24).
- req_byte  in  8  byte to insert.
- flush  in  1  discard every request not yet written back.
- rf_rd_en  out  1  register file read enable.
- rf_rd_addr  out  AW  register file read address.
- rf_rd_data  in  32  read data, valid one cycle after rf_rd_en. Read-during-write to the same address returns OLD data.
- rf_we  out  1  write enable; the write commits at the clock edge ending the cycle.
- rf_wr_addr  out  AW  write address.
- rf_wr_data  out  32  write data.
- busy  out  1  any stage valid.

Behaviour:
- One clock; reset is asynchronous and active-low.
- While rst_n=0, all stage valids, rf_we, rf_wr_addr and rf_wr_data are 0. rf_rd_en and busy are therefore 0.
- Stage A (registered request):
  - On each edge: a_valid <= req_valid & ~flush; a_rd/a_sel/a_byte <= req fields.
  - rf_rd_en = a_valid; rf_rd_addr = a_rd (combinational from A).
- Stage B (read return):
  - b_valid <= a_valid & ~flush; fields copied from A.
  - Operand selection, first match wins:
    1. b_rd==0 → 0.
    2. c_valid & c_rd==b_rd → c_data.
    3. d_valid & d_rd==b_rd → d_data.
    4. otherwise rf_rd_data.
  - merged = operand with bits [8*b_sel+7 : 8*b_sel] replaced by b_byte; other bits unchanged.
- Stage C (writeback, registered):
  - c_valid <= b_valid & ~flush; c_rd <= b_rd; c_data <= merged.
  - rf_we = c_valid & (c_rd != 0); rf_wr_addr = c_rd; rf_wr_data = c_data, all driven from C.
  - Writes to r0 are suppressed, but the op still completes.
- Stage D (write shadow): d_valid <= c_valid; d_rd/d_data <= C.
  - D covers the read that coincides with the C write (old-data regfile semantics).
  - D is NOT cleared by flush: its write has already committed.
- Flush is synchronous:
  - The C write in the flush cycle still happens. C reflects an op already merged, so its write is not squashed.
  - A and B are squashed, as is any request arriving in the flush cycle.
- Latency: request at edge t → rf_we high during cycle t+3. Throughput: 1 op/cycle, no stalls; req_ready is implicitly 1.
- Back-to-back ops to the same rd are fully serialised by forwarding. Four consecutive MOVBs to lanes 0..3 produce the full word.
- busy = a_valid | b_valid | c_valid.
- Reset mid-operation: all in-flight ops are lost, no partial write is issued, and D is cleared.

Decomposition:
- Shared cpu package: AW/NREG constants and the 2-bit byte-lane select type (LANE_B0..LANE_B3).
- One sub-module, byte_lane_merge: combinational; inputs lane, byte, word; output merged word. It also serves the existing byte-move mux path.
- Pipeline registers and forwarding stay in mov_byte_pipe.

Test Plan:
- Single op: reg r3=0x11223344 preloaded; request (r3, sel=2, 0xAA) → cycle t+3: rf_we=1, addr=3, data=0x11AA3344.
- Back-to-back: r5=0; requests at consecutive edges (r5,0,0xDD), (r5,1,0xCC), (r5,2,0xBB), (r5,3,0xAA) → writes 0x000000DD, 0x0000CCDD, 0x00BBCCDD, 0xAABBCCDD.
- Gap-of-one (D forwarding): r7=0xFFFFFFFF; (r7,0,0x00), idle, (r7,3,0x12) → second write 0x12FFFF00.
- r0 target: (r0,1,0x55) → rf_we stays 0 at t+3, busy drops after; a following (r0,0,0x01) still yields an internal operand of 0.
- Flush: three ops issued, flush asserted when the first is in C → only the first write occurs; busy=0 the next cycle.
- Async reset asserted mid-stream between edges → rf_we and busy fall immediately, no writes after release until new requests arrive.
